nibble_serial_subtractor: RTL

//   Multi-cycle subtractor: DIFF = A - B - BIN over 4*NIBBLES bits, one nibble per clock.

---
 rtl/sub_pkg.sv | 17 +
 rtl/nibble_cla_sub.sv | 37 +++
 rtl/nibble_serial_subtractor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared constants, FSM state type and sizing helper
// for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_cla_sub.sv
// Combinational 4-bit lookahead slice computing x + ~y + cin
// with flat sum-of-products carries.
module nibble_cla_sub (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = x & ~y;
  assign p = x ^ ~y;

  assign c1 = g[0]
            | (p[0] & cin);
  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & cin);
  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (&p & cin);

  assign d = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Wide A - B - BIN computed one nibble per clock through a
// single lookahead slice, with valid/ready on both sides.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         bin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  diff,
  output logic                         bout,
  output logic                         neg,
  output logic                         ovf,
  output logic                         zero
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = clog2_min1(NIBBLES);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           bout_q, bout_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;

  logic [3:0]     sl_d;
  logic           sl_cout;
  logic [W-1:0]   diff_nx;
  logic           last;

  nibble_cla_sub u_slice (
    .x    (a_q[3:0]),
    .y    (b_q[3:0]),
    .cin  (~borrow_q),
    .d    (sl_d),
    .cout (sl_cout)
  );

  // Result nibbles enter at the top and shift down.
  if (NIBBLES == 1) begin : g_one
    assign diff_nx = sl_d;
  end else begin : g_many
    assign diff_nx = {sl_d, diff_q[W-1:NIBBLE_W]};
  end

  assign last = (idx_q == IW'(NIBBLES - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> NIBBLE_W;
        b_d      = b_q >> NIBBLE_W;
        diff_d   = diff_nx;
        borrow_d = ~sl_cout;
        idx_d    = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          state_d = DONE;
          bout_d  = ~sl_cout;
          neg_d   = diff_nx[W-1];
          ovf_d   = (a_q[3] != b_q[3])
                 && (sl_d[3] != a_q[3]);
          zero_d  = (diff_nx == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = !rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
